// File: rtl/acc_drain_requant_pkg.sv
// rtl/acc_drain_requant_pkg.sv - shared widths, drain FSM states and config helpers
package acc_drain_requant_pkg;

    localparam int ACC_WIDTH   = 32;
    localparam int NUM_COLS    = 16;
    localparam int DEPTH_LOG2  = 8;
    localparam int OUT_WIDTH   = 8;
    localparam int MULT_WIDTH  = 16;
    localparam int SHIFT_WIDTH = 6;
    localparam int SHIFT_MAX   = 47;
    localparam int PROD_WIDTH  = ACC_WIDTH + MULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // Shifts beyond the product width are meaningless; pin them to the widest useful shift.
    function automatic logic [SHIFT_WIDTH-1:0] clamp_shift(input logic [SHIFT_WIDTH-1:0] s);
        return (s > SHIFT_WIDTH'(SHIFT_MAX)) ? SHIFT_WIDTH'(SHIFT_MAX) : s;
    endfunction

    // Final bank address of a drain; row counts above the bank depth drain the whole bank.
    function automatic logic [DEPTH_LOG2-1:0] last_row_addr(input logic [DEPTH_LOG2:0] rows);
        logic [DEPTH_LOG2:0] m1;
        m1 = rows - (DEPTH_LOG2+1)'(1);
        if (rows > (DEPTH_LOG2+1)'(2**DEPTH_LOG2)) begin
            return '1;
        end
        return m1[DEPTH_LOG2-1:0];
    endfunction

endpackage

// File: rtl/acc_drain_requant_if.sv
// rtl/acc_drain_requant_if.sv - requantised row stream towards the activation buffer
interface acc_drain_requant_if;
    import acc_drain_requant_pkg::*;

    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_COLS*OUT_WIDTH-1:0] out_data;
    logic                          out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/acc_drain_requant_lane.sv
// rtl/acc_drain_requant_lane.sv - one column: multiply, round/shift, zero point, saturate (DRAIN_RELU_EN adds ReLU)
module acc_drain_requant_lane
    import acc_drain_requant_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          advance,
    input  logic signed [ACC_WIDTH-1:0]   acc,
    input  logic signed [MULT_WIDTH-1:0]  mult,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic signed [OUT_WIDTH-1:0]   zp,
    output logic signed [OUT_WIDTH-1:0]   out
);
    localparam int BIAS_WIDTH = PROD_WIDTH + 2;
    localparam logic signed [BIAS_WIDTH-1:0] OUT_MAX = BIAS_WIDTH'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [BIAS_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [PROD_WIDTH:0]   rnd;
    logic signed [PROD_WIDTH:0]   rounded;
    logic signed [PROD_WIDTH:0]   shifted;
    logic signed [BIAS_WIDTH-1:0] biased;
    logic signed [OUT_WIDTH-1:0]  sat;
    logic signed [OUT_WIDTH-1:0]  res;

    // Stage 2: full-width signed product, moves with the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
        end else if (advance) begin
            prod <= PROD_WIDTH'(acc) * PROD_WIDTH'(mult);
        end
    end

    // Round half up at the shift point, then offset and clamp into the output range.
    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd[shift - SHIFT_WIDTH'(1)] = 1'b1;
        end
        rounded = $signed({prod[PROD_WIDTH-1], prod}) + rnd;
        shifted = rounded >>> shift;
        biased  = BIAS_WIDTH'(shifted) + BIAS_WIDTH'(zp);
        if (biased > OUT_MAX) begin
            sat = OUT_MAX[OUT_WIDTH-1:0];
        end else if (biased < OUT_MIN) begin
            sat = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat = biased[OUT_WIDTH-1:0];
        end
`ifdef DRAIN_RELU_EN
        res = (sat < zp) ? zp : sat;
`else
        res = sat;
`endif
    end

    // Stage 3: registered output element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (advance) begin
            out <= res;
        end
    end

endmodule

// File: rtl/acc_drain_requant.sv
// rtl/acc_drain_requant.sv - accumulator bank drain with per-column requantisation (option: DRAIN_RELU_EN)
module acc_drain_requant
    import acc_drain_requant_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DEPTH_LOG2:0]            row_count,
    input  logic signed [MULT_WIDTH-1:0]   quant_mult,
    input  logic [SHIFT_WIDTH-1:0]         quant_shift,
    input  logic signed [OUT_WIDTH-1:0]    quant_zp,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic [DEPTH_LOG2-1:0]          rd_addr,
    input  logic [NUM_COLS*ACC_WIDTH-1:0]  rd_data,
    acc_drain_requant_if.master            out_port
);
    drain_state_t                  state;
    logic signed [MULT_WIDTH-1:0]  mult_q;
    logic [SHIFT_WIDTH-1:0]        shift_q;
    logic signed [OUT_WIDTH-1:0]   zp_q;
    logic [DEPTH_LOG2-1:0]         last_addr_q;

    logic                          s1_valid, s1_last;
    logic                          s2_valid, s2_last;
    logic                          out_valid_q, out_last_q;
    logic [NUM_COLS*ACC_WIDTH-1:0] s1_data;
    logic [NUM_COLS*OUT_WIDTH-1:0] lane_out;
    logic                          advance;

    assign advance            = !out_valid_q || out_port.out_ready;
    assign out_port.out_valid = out_valid_q;
    assign out_port.out_last  = out_last_q;
    assign out_port.out_data  = lane_out;

    // Drain sequencer: latches config on start, walks addresses, waits for the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            mult_q      <= '0;
            shift_q     <= '0;
            zp_q        <= '0;
            last_addr_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mult_q      <= quant_mult;
                        shift_q     <= clamp_shift(quant_shift);
                        zp_q        <= quant_zp;
                        last_addr_q <= last_row_addr(row_count);
                        rd_addr     <= '0;
                        if (row_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        if (rd_addr == last_addr_q) begin
                            state   <= ST_FLUSH;
                            rd_en   <= 1'b0;
                            rd_addr <= '0;
                        end else begin
                            rd_addr <= rd_addr + DEPTH_LOG2'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_valid_q && out_port.out_ready && out_last_q) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid/last tags travel alongside the data through all three stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s2_valid    <= 1'b0;
            s2_last     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (advance) begin
            s1_valid    <= (state == ST_RUN);
            s1_last     <= (state == ST_RUN) && (rd_addr == last_addr_q);
            s2_valid    <= s1_valid;
            s2_last     <= s1_last;
            out_valid_q <= s2_valid;
            out_last_q  <= s2_last;
        end
    end

    // Stage 1: capture the combinational bank read for the issued address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data <= '0;
        end else if (advance) begin
            s1_data <= rd_data;
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
        acc_drain_requant_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance),
            .acc     (s1_data[c*ACC_WIDTH +: ACC_WIDTH]),
            .mult    (mult_q),
            .shift   (shift_q),
            .zp      (zp_q),
            .out     (lane_out[c*OUT_WIDTH +: OUT_WIDTH])
        );
    end

endmodule

// File: tb/tb_acc_drain_requant.sv
// tb/tb_acc_drain_requant.sv - directed bench with a row-level requant model and scoreboard
module tb_acc_drain_requant;
    import acc_drain_requant_pkg::*;

    localparam int RW = NUM_COLS*OUT_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic [DEPTH_LOG2:0]           row_count = '0;
    logic signed [MULT_WIDTH-1:0]  quant_mult = '0;
    logic [SHIFT_WIDTH-1:0]        quant_shift = '0;
    logic signed [OUT_WIDTH-1:0]   quant_zp = '0;
    logic                          busy, done, rd_en;
    logic [DEPTH_LOG2-1:0]         rd_addr;
    logic [NUM_COLS*ACC_WIDTH-1:0] rd_data;
    logic [NUM_COLS*ACC_WIDTH-1:0] mem [0:255];

    acc_drain_requant_if out_if();

    acc_drain_requant dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .row_count   (row_count),
        .quant_mult  (quant_mult),
        .quant_shift (quant_shift),
        .quant_zp    (quant_zp),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_port    (out_if)
    );

    always #5 clk = ~clk;
    assign rd_data = mem[rd_addr];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cfg_mult, cfg_shift, cfg_zp;
    logic [RW-1:0] exp_q[$];
    int col0_log[$];
    int beats = 0, done_cnt = 0, done_base = 0;
    int first_rd_en_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1, done_cyc = -1, last_rd_addr = -1;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [RW-1:0] prev_data = '0;
    logic [DEPTH_LOG2-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Requantisation of a single element straight from the arithmetic definition.
    function automatic int requant(input longint acc, input longint mult, input int sh, input longint zp);
        longint p, r, v;
        int s;
        s = (sh > 47) ? 47 : sh;
        p = acc * mult;
        if (s == 0) r = p;
        else r = (p + (longint'(1) << (s - 1))) >>> s;
        v = r + zp;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`ifdef DRAIN_RELU_EN
        if (v < zp) v = zp;
`endif
        return int'(v);
    endfunction

    function automatic logic [RW-1:0] model_row(input int r);
        logic [RW-1:0] row;
        logic signed [ACC_WIDTH-1:0] a;
        row = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            a = mem[r][c*ACC_WIDTH +: ACC_WIDTH];
            row[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(requant(longint'(a), longint'(cfg_mult), cfg_shift, longint'(cfg_zp)));
        end
        return row;
    endfunction

    task automatic fill_generic();
        int v;
        for (int r = 0; r < 256; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                v = (r*131 + c*977 + 13) * (c + 1);
                if (((r + c) % 3) == 0) v = -v;
                mem[r][c*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(v);
            end
        end
    endtask

    task automatic set_col0(input int r, input int v);
        mem[r][0 +: ACC_WIDTH] = ACC_WIDTH'(v);
    endtask

    task automatic do_start(input int rows, input int mult, input int sh, input int zp);
        int n;
        @(posedge clk); #1;
        row_count   = (DEPTH_LOG2+1)'(rows);
        quant_mult  = MULT_WIDTH'(mult);
        quant_shift = SHIFT_WIDTH'(sh);
        quant_zp    = OUT_WIDTH'(zp);
        cfg_mult = mult; cfg_shift = sh; cfg_zp = zp;
        n = (rows > 256) ? 256 : rows;
        for (int r = 0; r < n; r++) exp_q.push_back(model_row(r));
        beats = 0; col0_log.delete();
        first_rd_en_cyc = -1; first_valid_cyc = -1; last_rd_addr = -1;
        done_base = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // kind 0: ready held high; kind 1: 1010... then five cycles low, then high.
    task automatic wait_done(input int budget, input int kind, input string name);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (kind == 0) out_if.out_ready = 1'b1;
            else if (n < 14) out_if.out_ready = n[0];
            else if (n < 19) out_if.out_ready = 1'b0;
            else out_if.out_ready = 1'b1;
        end
        out_if.out_ready = 1'b1;
        vectors++;
        if (done_cnt == done_base) begin
            miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    // Scoreboard: every valid row must match the model in order; stalls must freeze outputs.
    always @(negedge clk) begin
        logic [RW-1:0] dummy;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (rd_en && first_rd_en_cyc < 0) first_rd_en_cyc = cyc;
            if (rd_en) last_rd_addr = int'(rd_addr);
            if (out_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                vectors++;
                if (!(out_if.out_valid && out_if.out_data == prev_data && rd_addr == prev_addr && out_if.out_last == prev_last)) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b data=%h addr=%0d required data=%h addr=%0d", out_if.out_valid, out_if.out_data, rd_addr, prev_data, prev_addr);
                end
            end
            if (out_if.out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: data=%h with nothing outstanding", out_if.out_data);
                end else if (out_if.out_data !== exp_q[0] || out_if.out_last !== (exp_q.size() == 1)) begin
                    miscompares++;
                    $display("FAIL row_%0d: data=%h last=%b required data=%h last=%b", beats, out_if.out_data, out_if.out_last, exp_q[0], exp_q.size() == 1);
                end
                if (out_if.out_ready) begin
                    if (exp_q.size() > 0) dummy = exp_q.pop_front();
                    col0_log.push_back(int'($signed(out_if.out_data[OUT_WIDTH-1:0])));
                    beats++;
                    last_hs_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                vectors++;
                if (exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL early_done: %0d rows still outstanding", exp_q.size());
                end
            end
            prev_stall = out_if.out_valid && !out_if.out_ready;
            prev_data  = out_if.out_data;
            prev_addr  = rd_addr;
            prev_last  = out_if.out_last;
        end
    end

    initial begin
        int n;
`ifdef DRAIN_RELU_EN
        int exp1 [4] = '{5, 0, 127, 0};
        int exp2 [4] = '{7, -1, 127, -1};
`else
        int exp1 [4] = '{5, -3, 127, -128};
        int exp2 [4] = '{7, -8, 127, -128};
`endif
        out_if.out_ready = 1'b1;
        fill_generic();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_if.out_valid, 0);
        check("rst_out_data", (out_if.out_data == '0) ? 1 : 0, 1);
        check("rst_out_last", out_if.out_last, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: identity requant, latency and back-to-back beats
        set_col0(0, 5); set_col0(1, -3); set_col0(2, 127); set_col0(3, -128);
        do_start(4, 1, 0, 0);
        wait_done(40, 0, "t1");
        check("t1_beats", beats, 4);
        check("t1_latency", first_valid_cyc - first_rd_en_cyc, 3);
        check("t1_consecutive", last_hs_cyc - first_valid_cyc, 3);
        check("t1_done_delay", done_cyc - last_hs_cyc, 1);
        for (int i = 0; i < 4; i++) check($sformatf("t1_col0_%0d", i), (col0_log.size() > i) ? col0_log[i] : 999, exp1[i]);

        // 2: scaled requant with rounding, zero point and saturation
        set_col0(0, 10); set_col0(1, -10); set_col0(2, 100000); set_col0(3, -100000);
        do_start(4, 3, 2, -1);
        wait_done(40, 0, "t2");
        for (int i = 0; i < 4; i++) check($sformatf("t2_col0_%0d", i), (col0_log.size() > i) ? col0_log[i] : 999, exp2[i]);

        // 3: backpressure pattern, in-order exactly-once delivery
        fill_generic();
        do_start(8, -300, 10, 3);
        wait_done(80, 1, "t3");
        check("t3_beats", beats, 8);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4a: empty drain
        do_start(0, 1, 0, 0);
        wait_done(20, 0, "t4a");
        repeat (4) @(posedge clk);
        check("t4a_beats", beats, 0);
        check("t4a_done_once", done_cnt - done_base, 1);

        // 4b: oversize row count clamps to full bank; start while busy ignored
        do_start(300, 7, 6, -2);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; quant_mult = MULT_WIDTH'(5); row_count = (DEPTH_LOG2+1)'(4);
        @(negedge clk);
        check("t4b_busy", busy, 1);
        @(posedge clk); #1 start = 1'b0;
        wait_done(600, 0, "t4b");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4b_beats", beats, 256);
        check("t4b_last_addr", last_rd_addr, 255);
        check("t4b_done_once", done_cnt - done_base, 1);
        check("t4b_idle_addr", rd_addr, 0);
        check("t4b_idle_rd_en", rd_en, 0);
        check("t4b_idle_busy", busy, 0);

        // 5: reset mid-drain then a fresh full drain
        do_start(6, 2, 1, 4);
        n = 0;
        while (beats < 2 && n < 50) begin
            @(posedge clk); n++;
        end
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_rd_en", rd_en, 0);
        check("t5_abort_valid", out_if.out_valid, 0);
        check("t5_abort_data", (out_if.out_data == '0) ? 1 : 0, 1);
        check("t5_abort_last", out_if.out_last, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("t5_no_done", done_cnt - done_base, 0);
        do_start(6, 2, 1, 4);
        wait_done(40, 0, "t5");
        check("t5_beats", beats, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
